mp_frame_scheduler: RTL and testbench

- Frame-level controller for the MotionPredict block.
- Counts off the background-training frames, then on each new camera frame:
  - clears MotionPredict and starts it;
  - services each per-pixel coordinate request by fetching the RGB and background statistics from the frame-buffer read port;
  - returns them to MotionPredict with a one-cycle valid;
  - captures the final bounding box.
- Sits between the camera frame buffer (SDRAM read arbiter) and MotionPredict. A watchdog recovers from a stalled read or a hung detector.

---
 rtl/mp_frame_scheduler.sv | 177 +++++++++++++++++
 tb/tb_mp_frame_scheduler.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mp_frame_scheduler.sv
// mp_frame_scheduler: frame sequencer for MotionPredict.
// Background training, pixel fetch service, box capture, watchdog.
module mp_frame_scheduler #(
  parameter int WIDTH        = 640,
  parameter int HEIGHT       = 480,
  parameter int TRAIN_FRAMES = 32,
  parameter int TIMEOUT      = 4096,
  parameter int NOT_FOUND    = 2023
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_enable,
  input  logic        i_frame_start,
  output logic        o_rd_req,
  output logic [18:0] o_rd_addr,
  input  logic        i_rd_ack,
  input  logic [39:0] i_rd_data,
  output logic        o_mp_rst_n,
  output logic        o_mp_start,
  input  logic        i_mp_coord_valid,
  input  logic [10:0] i_mp_x,
  input  logic [10:0] i_mp_y,
  output logic [7:0]  o_mp_r,
  output logic [7:0]  o_mp_g,
  output logic [7:0]  o_mp_b,
  output logic [7:0]  o_mp_pix_x,
  output logic [7:0]  o_mp_pix_x2,
  output logic        o_mp_valid,
  input  logic        i_mp_o_valid,
  input  logic [10:0] i_mp_up_y,
  input  logic [10:0] i_mp_down_y,
  input  logic [10:0] i_mp_left_x,
  input  logic [10:0] i_mp_right_x,
  output logic        o_box_valid,
  output logic        o_found,
  output logic [10:0] o_top,
  output logic [10:0] o_bottom,
  output logic [10:0] o_left,
  output logic [10:0] o_right,
  output logic        o_training,
  output logic        o_busy,
  output logic        o_timeout_err,
  output logic [7:0]  o_drop_cnt
);

  typedef enum logic [3:0] {
    S_TRAIN, S_IDLE, S_CLR, S_START, S_WAIT,
    S_FETCH, S_OOR, S_PRESENT, S_DONE, S_ABORT
  } state_t;

  localparam int TW = $clog2(TRAIN_FRAMES + 1);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [10:0]   XLIM  = 11'(WIDTH);
  localparam logic [10:0]   YLIM  = 11'(HEIGHT);
  localparam logic [10:0]   NF    = 11'(NOT_FOUND);
  localparam logic [TW-1:0] TLAST = TW'(TRAIN_FRAMES - 1);
  localparam logic [WW-1:0] WLAST = WW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [TW-1:0] train_q;
  logic [WW-1:0] wd_q;
  logic [10:0]   x_q, y_q;
  logic          in_range, wd_hit, busy_now, drop_ev;

  assign in_range = (i_mp_x < XLIM) && (i_mp_y < YLIM);
  assign wd_hit   = (wd_q == WLAST);
  assign busy_now = state_q inside {S_CLR, S_START, S_WAIT,
                                   S_FETCH, S_OOR, S_PRESENT, S_DONE};
  assign drop_ev  = i_frame_start &&
                    (busy_now || (state_q == S_IDLE && !i_enable));
  assign o_rd_addr = 19'(y_q) * 19'(WIDTH) + 19'(x_q);

  // Next-state selection; box result beats a coincident coordinate request.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_TRAIN:
        if (i_frame_start && train_q == TLAST) state_d = S_IDLE;
      S_IDLE:
        if (i_frame_start && i_enable) state_d = S_CLR;
      S_CLR:   state_d = S_START;
      S_START: state_d = S_WAIT;
      S_WAIT:
        if (i_mp_o_valid)          state_d = S_DONE;
        else if (i_mp_coord_valid) state_d = in_range ? S_FETCH : S_OOR;
        else if (wd_hit)           state_d = S_ABORT;
      S_FETCH:
        if (i_rd_ack)    state_d = S_PRESENT;
        else if (wd_hit) state_d = S_ABORT;
      S_OOR:     state_d = S_PRESENT;
      S_PRESENT: state_d = S_WAIT;
      S_DONE:    state_d = S_IDLE;
      S_ABORT:   state_d = S_IDLE;
      default:   state_d = S_TRAIN;
    endcase
  end

  // State, counters, latched data and registered Moore outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q       <= S_TRAIN;
      train_q       <= '0;
      wd_q          <= '0;
      x_q           <= '0;
      y_q           <= '0;
      o_rd_req      <= 1'b0;
      o_mp_rst_n    <= 1'b0;
      o_mp_start    <= 1'b0;
      o_mp_valid    <= 1'b0;
      o_mp_r        <= '0;
      o_mp_g        <= '0;
      o_mp_b        <= '0;
      o_mp_pix_x    <= '0;
      o_mp_pix_x2   <= '0;
      o_box_valid   <= 1'b0;
      o_found       <= 1'b0;
      o_top         <= '0;
      o_bottom      <= '0;
      o_left        <= '0;
      o_right       <= '0;
      o_training    <= 1'b1;
      o_busy        <= 1'b0;
      o_timeout_err <= 1'b0;
      o_drop_cnt    <= '0;
    end else begin
      state_q     <= state_d;
      o_training  <= (state_d == S_TRAIN);
      o_mp_rst_n  <= !(state_d inside {S_CLR, S_ABORT});
      o_mp_start  <= (state_d == S_START);
      o_rd_req    <= (state_d == S_FETCH);
      o_mp_valid  <= (state_d == S_PRESENT);
      o_box_valid <= (state_d == S_DONE);
      o_busy      <= state_d inside {S_CLR, S_START, S_WAIT,
                                     S_FETCH, S_OOR, S_PRESENT, S_DONE};
      if (state_q == S_TRAIN && i_frame_start)
        train_q <= (train_q == TLAST) ? '0 : train_q + 1'b1;
      if (state_d != state_q)
        wd_q <= '0;
      else if (state_q == S_WAIT || state_q == S_FETCH)
        wd_q <= wd_q + 1'b1;
      if (state_d == S_CLR) begin
        x_q <= '0;
        y_q <= '0;
      end
      if (state_q == S_WAIT && state_d inside {S_FETCH, S_OOR}) begin
        x_q <= i_mp_x;
        y_q <= i_mp_y;
      end
      if (state_q == S_WAIT && state_d == S_OOR) begin
        o_mp_r      <= '0;
        o_mp_g      <= '0;
        o_mp_b      <= '0;
        o_mp_pix_x  <= '0;
        o_mp_pix_x2 <= '0;
      end
      if (state_q == S_FETCH && state_d == S_PRESENT) begin
        o_mp_r      <= i_rd_data[39:32];
        o_mp_g      <= i_rd_data[31:24];
        o_mp_b      <= i_rd_data[23:16];
        o_mp_pix_x  <= i_rd_data[15:8];
        o_mp_pix_x2 <= i_rd_data[7:0];
      end
      if (state_q == S_WAIT && state_d == S_DONE) begin
        o_top    <= i_mp_up_y;
        o_bottom <= i_mp_down_y;
        o_left   <= i_mp_left_x;
        o_right  <= i_mp_right_x;
        o_found  <= (i_mp_up_y != NF);
      end
      if (state_d == S_ABORT)
        o_timeout_err <= 1'b1;
      if (drop_ev && o_drop_cnt != 8'hFF)
        o_drop_cnt <= o_drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_mp_frame_scheduler.sv
// tb_mp_frame_scheduler: scoreboard bench for mp_frame_scheduler.
// Random requests checked against a frame-level reference model.
module tb_mp_frame_scheduler;

  logic        i_clk = 1'b0;
  logic        i_rst, i_enable, i_frame_start, i_rd_ack;
  logic [39:0] i_rd_data;
  logic        i_mp_coord_valid, i_mp_o_valid;
  logic [10:0] i_mp_x, i_mp_y;
  logic [10:0] i_mp_up_y, i_mp_down_y, i_mp_left_x, i_mp_right_x;
  logic        o_rd_req, o_mp_rst_n, o_mp_start, o_mp_valid;
  logic [18:0] o_rd_addr;
  logic [7:0]  o_mp_r, o_mp_g, o_mp_b, o_mp_pix_x, o_mp_pix_x2;
  logic        o_box_valid, o_found, o_training, o_busy, o_timeout_err;
  logic [10:0] o_top, o_bottom, o_left, o_right;
  logic [7:0]  o_drop_cnt;

  mp_frame_scheduler dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_enable(i_enable),
    .i_frame_start(i_frame_start), .o_rd_req(o_rd_req),
    .o_rd_addr(o_rd_addr), .i_rd_ack(i_rd_ack), .i_rd_data(i_rd_data),
    .o_mp_rst_n(o_mp_rst_n), .o_mp_start(o_mp_start),
    .i_mp_coord_valid(i_mp_coord_valid), .i_mp_x(i_mp_x), .i_mp_y(i_mp_y),
    .o_mp_r(o_mp_r), .o_mp_g(o_mp_g), .o_mp_b(o_mp_b),
    .o_mp_pix_x(o_mp_pix_x), .o_mp_pix_x2(o_mp_pix_x2),
    .o_mp_valid(o_mp_valid), .i_mp_o_valid(i_mp_o_valid),
    .i_mp_up_y(i_mp_up_y), .i_mp_down_y(i_mp_down_y),
    .i_mp_left_x(i_mp_left_x), .i_mp_right_x(i_mp_right_x),
    .o_box_valid(o_box_valid), .o_found(o_found), .o_top(o_top),
    .o_bottom(o_bottom), .o_left(o_left), .o_right(o_right),
    .o_training(o_training), .o_busy(o_busy),
    .o_timeout_err(o_timeout_err), .o_drop_cnt(o_drop_cnt)
  );

  always #5 i_clk = ~i_clk;

  typedef struct { logic [39:0] d; bit oor; int rcyc; } pix_t;
  typedef struct { logic [44:0] v; int rcyc; } box_t;

  pix_t        pix_q[$];
  box_t        box_q[$];
  logic [18:0] addr_q[$];
  int          exp_starts = 0;
  int          exp_drops = 0;
  int          checks = 0;
  int          passed = 0;
  int          cyc = 0;
  int          ack_cyc = 0;
  int          rd_lat = 0;
  bit          ack_block = 0;
  bit          use_fixed = 0;
  logic [39:0] fixed_data = 40'h0;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input bit ok,
                     input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (ok) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // Frame buffer contents as a pure function of the pixel address.
  function automatic logic [39:0] mem_fn(input int a);
    logic [31:0] u;
    u = 32'(a);
    return {u[7:0] ^ 8'h3C, u[15:8], u[18:11] ^ 8'h99, ~u[7:0], u[10:3]};
  endfunction

  function automatic bit ev(input int sel);
    case (sel)
      0:       return o_mp_start;
      1:       return o_mp_valid;
      default: return o_box_valid;
    endcase
  endfunction

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wait_ev(input int sel, input int max, input string nm);
    int n = 0;
    while (!ev(sel) && n < max) begin
      step();
      n++;
    end
    chk(nm, ev(sel), 64'(n), 64'(max));
  endtask

  task automatic pulse_fs();
    i_frame_start = 1'b1;
    step();
    i_frame_start = 1'b0;
    step();
  endtask

  task automatic start_frame();
    exp_starts++;
    i_frame_start = 1'b1;
    step();
    i_frame_start = 1'b0;
    chk("clr_rstn_low", o_mp_rst_n == 1'b0, 64'(o_mp_rst_n), 64'd0);
    chk("clr_busy", o_busy == 1'b1, 64'(o_busy), 64'd1);
    step();
    chk("start_pulse", o_mp_start == 1'b1, 64'(o_mp_start), 64'd1);
    step();
  endtask

  task automatic do_req(input int x, input int y, input int lat);
    pix_t e;
    bit   inr;
    inr = (x < 640) && (y < 480);
    rd_lat = lat;
    e.d = !inr ? 40'h0 : (use_fixed ? fixed_data : mem_fn(y * 640 + x));
    e.oor = !inr;
    e.rcyc = cyc;
    if (inr) addr_q.push_back(19'(y * 640 + x));
    pix_q.push_back(e);
    i_mp_coord_valid = 1'b1;
    i_mp_x = 11'(x);
    i_mp_y = 11'(y);
    step();
    i_mp_coord_valid = 1'b0;
    wait_ev(1, 64, "pix_arrive");
    step();
  endtask

  task automatic do_box(input int up, input int dn, input int lf,
                        input int rt, input bit with_coord);
    box_t b;
    b.v = {up != 2023, 11'(up), 11'(dn), 11'(lf), 11'(rt)};
    b.rcyc = cyc;
    box_q.push_back(b);
    i_mp_o_valid = 1'b1;
    i_mp_up_y = 11'(up);
    i_mp_down_y = 11'(dn);
    i_mp_left_x = 11'(lf);
    i_mp_right_x = 11'(rt);
    if (with_coord) begin
      i_mp_coord_valid = 1'b1;
      i_mp_x = 11'd3;
      i_mp_y = 11'd4;
    end
    step();
    i_mp_o_valid = 1'b0;
    i_mp_coord_valid = 1'b0;
    wait_ev(2, 8, "box_arrive");
    chk("busy_in_done", o_busy == 1'b1, 64'(o_busy), 64'd1);
    step();
    chk("idle_after_done", o_busy == 1'b0, 64'(o_busy), 64'd0);
  endtask

  // Frame-buffer read port: acks after rd_lat cycles with mem_fn data.
  initial begin : responder
    logic [18:0] a;
    bit acked;
    acked = 0;
    i_rd_ack = 1'b0;
    i_rd_data = '0;
    forever begin
      step();
      i_rd_ack = 1'b0;
      if (acked) begin
        chk("rd_req_drop", o_rd_req == 1'b0, 64'(o_rd_req), 64'd0);
        acked = 0;
      end
      if (o_rd_req && !ack_block) begin
        a = o_rd_addr;
        for (int i = 0; i < rd_lat; i++) step();
        chk("rd_addr_stable", o_rd_addr == a, 64'(o_rd_addr), 64'(a));
        i_rd_data = use_fixed ? fixed_data : mem_fn(int'(a));
        i_rd_ack = 1'b1;
        ack_cyc = cyc;
        acked = 1;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents an output.
  initial begin : monitor
    bit   p_req, p_rstn, p_val;
    pix_t pe;
    box_t be;
    logic [18:0] ea;
    logic [44:0] got;
    p_req = 0;
    p_rstn = 0;
    p_val = 0;
    forever begin
      @(negedge i_clk);
      if (o_rd_req && !p_req) begin
        chk("rd_req_expected", addr_q.size() > 0,
            64'(o_rd_addr), 64'd0);
        if (addr_q.size() > 0) begin
          ea = addr_q.pop_front();
          chk("rd_addr", o_rd_addr == ea, 64'(o_rd_addr), 64'(ea));
        end
      end
      if (o_mp_valid) begin
        chk("pix_single", !p_val, 64'(p_val), 64'd0);
        chk("pix_expected", pix_q.size() > 0, 64'(o_mp_valid), 64'd0);
        if (pix_q.size() > 0) begin
          pe = pix_q.pop_front();
          chk("pix_data",
              {o_mp_r, o_mp_g, o_mp_b, o_mp_pix_x, o_mp_pix_x2} == pe.d,
              64'({o_mp_r, o_mp_g, o_mp_b, o_mp_pix_x, o_mp_pix_x2}),
              64'(pe.d));
          if (pe.oor)
            chk("pix_lat_oor", cyc == pe.rcyc + 2,
                64'(cyc - pe.rcyc), 64'd2);
          else
            chk("pix_lat_ack", cyc == ack_cyc + 1,
                64'(cyc - ack_cyc), 64'd1);
        end
      end
      if (o_box_valid) begin
        chk("box_expected", box_q.size() > 0, 64'(o_box_valid), 64'd0);
        if (box_q.size() > 0) begin
          be = box_q.pop_front();
          got = {o_found, o_top, o_bottom, o_left, o_right};
          chk("box_data", got == be.v, 64'(got), 64'(be.v));
          chk("box_lat", cyc == be.rcyc + 1, 64'(cyc - be.rcyc), 64'd1);
        end
      end
      if (o_mp_start) begin
        chk("start_expected", exp_starts > 0, 64'(o_mp_start), 64'd0);
        chk("start_after_clr", !p_rstn, 64'(p_rstn), 64'd0);
        if (exp_starts > 0) exp_starts--;
      end
      p_req = o_rd_req;
      p_rstn = o_mp_rst_n;
      p_val = o_mp_valid;
    end
  end

  initial begin : guard
    #400000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin : stim
    int k, n, up;
    i_rst = 1'b1;
    i_enable = 1'b1;
    i_frame_start = 1'b0;
    i_mp_coord_valid = 1'b0;
    i_mp_o_valid = 1'b0;
    i_mp_x = '0;
    i_mp_y = '0;
    i_mp_up_y = '0;
    i_mp_down_y = '0;
    i_mp_left_x = '0;
    i_mp_right_x = '0;
    repeat (3) step();
    chk("rst_flags",
        {o_training, o_mp_rst_n, o_busy, o_rd_req, o_mp_start,
         o_mp_valid, o_box_valid, o_timeout_err, o_found} == 9'b1_0000_0000,
        64'({o_training, o_mp_rst_n, o_busy, o_rd_req, o_mp_start,
             o_mp_valid, o_box_valid, o_timeout_err, o_found}),
        64'h100);
    chk("rst_data", {o_drop_cnt, o_rd_addr, o_top} == '0,
        64'({o_drop_cnt, o_rd_addr, o_top}), 64'd0);
    i_rst = 1'b0;
    step();
    chk("train_rstn", o_mp_rst_n == 1'b1, 64'(o_mp_rst_n), 64'd1);

    // Training: 31 pulses keep training, the 32nd ends it.
    repeat (31) pulse_fs();
    chk("train_31", o_training == 1'b1, 64'(o_training), 64'd1);
    pulse_fs();
    chk("train_32", o_training == 1'b0, 64'(o_training), 64'd0);
    chk("train_nodrop", o_drop_cnt == 8'd0, 64'(o_drop_cnt), 64'd0);

    // Directed frame: drops while busy, fetch path, boundaries, box.
    start_frame();
    repeat (3) pulse_fs();
    exp_drops += 3;
    chk("drop_busy", o_drop_cnt == 8'(exp_drops),
        64'(o_drop_cnt), 64'(exp_drops));
    use_fixed = 1;
    fixed_data = 40'hFF80402010;
    do_req(5, 2, 3);
    use_fixed = 0;
    chk("pix_hold",
        {o_mp_valid, o_mp_r, o_mp_g, o_mp_b, o_mp_pix_x, o_mp_pix_x2}
          == 41'h0FF80402010,
        64'({o_mp_valid, o_mp_r, o_mp_g, o_mp_b, o_mp_pix_x, o_mp_pix_x2}),
        64'h0FF80402010);
    do_req(639, 479, 1);
    do_req(640, 0, 0);
    do_req(0, 480, 2);
    do_req(0, 0, 0);
    do_box(10, 50, 30, 90, 0);
    chk("box_hold", {o_found, o_top, o_bottom, o_left, o_right}
          == {1'b1, 11'd10, 11'd50, 11'd30, 11'd90},
        64'({o_found, o_top, o_bottom, o_left, o_right}),
        64'({1'b1, 11'd10, 11'd50, 11'd30, 11'd90}));

    // Not-found sentinel.
    start_frame();
    do_req(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)), 1);
    do_box(2023, 5, 6, 7, 0);
    chk("not_found", o_found == 1'b0, 64'(o_found), 64'd0);

    // Coordinate and result in the same cycle: result wins.
    start_frame();
    do_box(20, 40, 60, 80, 1);

    // Randomized frames.
    for (int f = 0; f < 6; f++) begin
      start_frame();
      n = int'($urandom_range(2, 8));
      for (int r = 0; r < n; r++)
        do_req(int'($urandom_range(0, 700)), int'($urandom_range(0, 520)),
               int'($urandom_range(0, 4)));
      up = ($urandom_range(0, 3) == 0) ? 2023 : int'($urandom_range(0, 479));
      do_box(up, int'($urandom_range(0, 2047)),
             int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)), 0);
    end

    // Disabled: frames ignored and counted, saturating.
    i_enable = 1'b0;
    for (int i = 0; i < 300; i++) begin
      pulse_fs();
      if (exp_drops < 255) exp_drops++;
    end
    chk("drop_sat", o_drop_cnt == 8'(exp_drops),
        64'(o_drop_cnt), 64'(exp_drops));
    chk("disabled_idle", o_busy == 1'b0, 64'(o_busy), 64'd0);
    i_enable = 1'b1;

    // Watchdog: read never acknowledged.
    ack_block = 1;
    start_frame();
    addr_q.push_back(19'(100 * 640 + 200));
    i_mp_coord_valid = 1'b1;
    i_mp_x = 11'd200;
    i_mp_y = 11'd100;
    k = cyc;
    step();
    i_mp_coord_valid = 1'b0;
    n = 0;
    while (!o_timeout_err && n < 5000) begin
      step();
      n++;
    end
    chk("timeout_flag", o_timeout_err == 1'b1, 64'(o_timeout_err), 64'd1);
    chk("timeout_cycle", cyc == k + 4097, 64'(cyc - k), 64'd4097);
    chk("timeout_abort",
        {o_rd_req, o_mp_rst_n, o_busy, o_box_valid} == 4'b0000,
        64'({o_rd_req, o_mp_rst_n, o_busy, o_box_valid}), 64'd0);
    step();
    chk("abort_release", {o_mp_rst_n, o_busy} == 2'b10,
        64'({o_mp_rst_n, o_busy}), 64'h2);
    ack_block = 0;

    // Recovery frame; error flag stays set.
    start_frame();
    do_req(321, 123, 2);
    do_box(1, 2, 3, 4, 0);
    chk("timeout_sticky", o_timeout_err == 1'b1, 64'(o_timeout_err), 64'd1);

    // Asynchronous reset mid-frame restarts training.
    start_frame();
    i_rst = 1'b1;
    #1;
    chk("async_rst", {o_training, o_busy, o_mp_rst_n, o_timeout_err}
          == 4'b1000,
        64'({o_training, o_busy, o_mp_rst_n, o_timeout_err}), 64'h8);
    step();
    i_rst = 1'b0;
    exp_drops = 0;
    chk("rst_drop_clr", o_drop_cnt == 8'(exp_drops),
        64'(o_drop_cnt), 64'(exp_drops));
    repeat (31) pulse_fs();
    chk("retrain_31", o_training == 1'b1, 64'(o_training), 64'd1);
    pulse_fs();
    chk("retrain_32", o_training == 1'b0, 64'(o_training), 64'd0);
    start_frame();
    do_req(17, 9, 0);
    do_box(100, 200, 300, 400, 0);

    repeat (4) step();
    chk("pix_q_empty", pix_q.size() == 0, 64'(pix_q.size()), 64'd0);
    chk("box_q_empty", box_q.size() == 0, 64'(box_q.size()), 64'd0);
    chk("starts_done", exp_starts == 0, 64'(exp_starts), 64'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
